// File: rtl/cascade_down_timer_pkg.sv
// Shared types and constants for the cascaded down-timer.
// DOWN_TIMER_BCD_EN selects decimal (9..0) stages instead of binary (F..0).
package cascade_down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIBBLES = 4;

`ifdef DOWN_TIMER_BCD_EN
    localparam logic [3:0] STAGE_MAX = 4'd9;
`else
    localparam logic [3:0] STAGE_MAX = 4'hF;
`endif

    // Out-of-range digits are forced to the stage maximum at load time.
    function automatic logic [3:0] clamp_nibble(input logic [3:0] v);
        return (v > STAGE_MAX) ? STAGE_MAX : v;
    endfunction

endpackage

// File: rtl/down_nibble_stage.sv
// One 4-bit down-counting stage; wraps 0 -> STAGE_MAX when borrowed from.
// Under DOWN_TIMER_BCD_EN the stage is a decimal digit.
module down_nibble_stage
    import cascade_down_timer_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bo
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= 4'd0;
        end else if (load) begin
            q <= clamp_nibble(d);
        end else if (bin) begin
            q <= (q == 4'd0) ? STAGE_MAX : q - 4'd1;
        end
    end

    assign bo = bin && (q == 4'd0);

endmodule

// File: rtl/cascade_down_timer.sv
// 16-bit loadable down-timer from four nibble stages, with prescaler,
// terminal-count pulse and optional auto-reload. DOWN_TIMER_BCD_EN: BCD stages.
//
//   state   | meaning
//   IDLE    | after clear, waiting for a load
//   RUN     | counting down on each prescaled step (busy=1)
//   DONE    | expired, Q held at 0 until the next load
module cascade_down_timer
    import cascade_down_timer_pkg::*;
#(
    parameter bit          AUTO_RELOAD = 1'b0,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 load,
    input  logic [15:0]          D,
    input  logic                 en,
    output logic [15:0]          Q,
    output logic [NIBBLES-1:0]   Bo,
    output logic                 tc,
    output logic                 busy
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    state_t             state, state_nxt;
    logic [15:0]        period;
    logic [15:0]        presc;
    logic               step;
    logic               reload;
    logic               dec_en;
    logic               expire;
    logic               stage_load;
    logic [15:0]        stage_d;
    logic [NIBBLES-1:0] bin;

    assign step       = en && (state == ST_RUN) && (presc == PRESC_LAST);
    // With auto-reload the step after expiry restores the period instead of wrapping.
    assign reload     = AUTO_RELOAD && step && !load && (Q == 16'd0);
    assign dec_en     = step && !reload && !load;
    assign expire     = dec_en && (Q == 16'd1);
    assign stage_load = load || reload;
    assign stage_d    = load ? D : period;

    always_ff @(posedge clk) begin
        if (clear) begin
            state  <= ST_IDLE;
            period <= 16'd0;
            presc  <= 16'd0;
            tc     <= 1'b0;
        end else begin
            state <= state_nxt;
            tc    <= expire;
            if (load) begin
                period <= D;
                presc  <= 16'd0;
            end else if (en && (state == ST_RUN)) begin
                presc <= step ? 16'd0 : presc + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state == ST_RUN);
        if (load) begin
            state_nxt = (D != 16'd0) ? ST_RUN : ST_DONE;
        end else if (expire && !AUTO_RELOAD) begin
            state_nxt = ST_DONE;
        end
    end

    // Borrow-in is a lookahead on the lower nibbles; it equals the bo of the stage below.
    for (genvar i = 0; i < NIBBLES; i++) begin : g_stage
        if (i == 0) begin : g_lsb
            assign bin[i] = dec_en;
        end else begin : g_upper
            assign bin[i] = dec_en && (Q[4*i-1:0] == '0);
        end

        down_nibble_stage u_stage (
            .clk   (clk),
            .clear (clear),
            .load  (stage_load),
            .d     (stage_d[4*i +: 4]),
            .bin   (bin[i]),
            .q     (Q[4*i +: 4]),
            .bo    (Bo[i])
        );
    end

endmodule

// File: tb/tb_cascade_down_timer.sv
// Directed self-checking bench for cascade_down_timer (default and auto-reload/prescaled instances).
module tb_cascade_down_timer;

    logic        clk = 1'b0;
    logic        clear;
    logic        load0, en0;
    logic [15:0] d0;
    logic [15:0] q0;
    logic [3:0]  bo0;
    logic        tc0, busy0;
    logic        load1, en1;
    logic [15:0] d1;
    logic [15:0] q1;
    logic [3:0]  bo1;
    logic        tc1, busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cascade_down_timer u0 (
        .clk(clk), .clear(clear), .load(load0), .D(d0), .en(en0),
        .Q(q0), .Bo(bo0), .tc(tc0), .busy(busy0)
    );

    cascade_down_timer #(.AUTO_RELOAD(1'b1), .PRESCALE(4)) u1 (
        .clk(clk), .clear(clear), .load(load1), .D(d1), .en(en1),
        .Q(q1), .Bo(bo1), .tc(tc1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] ripple_exp;
        logic [15:0] q_exp;
        int          phase;
`ifdef DOWN_TIMER_BCD_EN
        ripple_exp = 16'h0999;
`else
        ripple_exp = 16'h0FFF;
`endif
        clear = 1'b1; load0 = 1'b1; d0 = 16'h1234; en0 = 1'b0;
        load1 = 1'b0; d1 = 16'h0000; en1 = 1'b0;

        // reset dominates a simultaneous load
        tick(); tick();
        clear = 1'b0; load0 = 1'b0;
        tick();
        check("rst_q",    32'(q0),    32'h0);
        check("rst_bo",   32'(bo0),   32'h0);
        check("rst_tc",   32'(tc0),   32'h0);
        check("rst_busy", 32'(busy0), 32'h0);

        // simple countdown 3,2,1,0
        load0 = 1'b1; d0 = 16'h0003; en0 = 1'b1;
        tick();
        load0 = 1'b0;
        check("cnt_q3",    32'(q0),    32'h3);
        check("cnt_busy3", 32'(busy0), 32'h1);
        check("cnt_tc3",   32'(tc0),   32'h0);
        tick();
        check("cnt_q2",  32'(q0),  32'h2);
        check("cnt_tc2", 32'(tc0), 32'h0);
        tick();
        check("cnt_q1",  32'(q0),  32'h1);
        check("cnt_tc1", 32'(tc0), 32'h0);
        tick();
        check("cnt_q0",    32'(q0),    32'h0);
        check("cnt_tc0",   32'(tc0),   32'h1);
        check("cnt_busy0", 32'(busy0), 32'h0);
        tick();
        check("done_q",    32'(q0),    32'h0);
        check("done_tc",   32'(tc0),   32'h0);
        check("done_busy", 32'(busy0), 32'h0);

        // borrow ripple across three zero stages
        en0 = 1'b0; load0 = 1'b1; d0 = 16'h1000;
        tick();
        load0 = 1'b0;
        check("rip_load", 32'(q0),    32'h1000);
        check("rip_busy", 32'(busy0), 32'h1);
        en0 = 1'b1;
        #1;
        check("rip_bo", 32'(bo0), 32'h7);
        tick();
        en0 = 1'b0;
        check("rip_q", 32'(q0), 32'(ripple_exp));

        // pause at 7 for five cycles
        load0 = 1'b1; d0 = 16'h0008; en0 = 1'b1;
        tick();
        load0 = 1'b0;
        check("pz_q8", 32'(q0), 32'h8);
        tick();
        check("pz_q7", 32'(q0), 32'h7);
        en0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pz_hold_q",  32'(q0),  32'h7);
            check("pz_hold_tc", 32'(tc0), 32'h0);
        end
        en0 = 1'b1;
        tick();
        check("pz_resume", 32'(q0), 32'h6);

        // load collides with the would-be terminal count
        for (int v = 5; v >= 1; v--) begin
            tick();
            check("col_down", 32'(q0), 32'(v));
        end
        load0 = 1'b1; d0 = 16'h0005;
        tick();
        load0 = 1'b0;
        check("col_q",    32'(q0),    32'h5);
        check("col_tc",   32'(tc0),   32'h0);
        check("col_busy", 32'(busy0), 32'h1);
        tick(); tick();
        check("abort_pre", 32'(q0), 32'h3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_q",    32'(q0),    32'h0);
        check("abort_tc",   32'(tc0),   32'h0);
        check("abort_busy", 32'(busy0), 32'h0);
        tick();
        check("idle_hold_q",  32'(q0),  32'h0);
        check("idle_hold_tc", 32'(tc0), 32'h0);

        // load of zero goes straight to DONE without a pulse
        load0 = 1'b1; d0 = 16'h0000;
        tick();
        load0 = 1'b0;
        check("zero_q",    32'(q0),    32'h0);
        check("zero_tc",   32'(tc0),   32'h0);
        check("zero_busy", 32'(busy0), 32'h0);
        tick();
        check("zero_tc2", 32'(tc0), 32'h0);

        // auto-reload, prescale 4: Q 2,1,0 each held 4 cycles, tc every 12
        load1 = 1'b1; d1 = 16'h0002; en1 = 1'b1;
        tick();
        load1 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            phase = k % 12;
            q_exp = 16'(2 - phase / 4);
            check("ar_q",    32'(q1),    32'(q_exp));
            check("ar_tc",   32'(tc1),   (phase == 8) ? 32'h1 : 32'h0);
            check("ar_busy", 32'(busy1), 32'h1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
